shift_seq_ctrl: RTL and testbench

Command-driven sequencer for the 4-digit rotate/shift register datapath. It accepts a command holding a shift mode and a step count, and holds `mode` stable to the shifter for the whole command. It issues exactly `count` single-cycle `en` strobes, spaced by a programmable prescaler, then pulses `done`. It sits between the button/FSM front end and the shifter, and replaces free-running `en`.

---
 rtl/shift_seq_ctrl.sv | 149 ++++++++++++++
 tb/tb_shift_seq_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - command-driven step sequencer for the rotate/shift datapath
//
// Accepts one command {mode, count} at a time and then issues exactly
// `count` single-cycle `en` strobes to the shifter, one every TICK_DIV clocks.
// After the last strobe it raises `done` for one cycle and becomes ready again.
// `mode` is latched at accept and held until the next accept.
//
// Optional feature macro: SEQ_ABORT_EN (adds the `abort` input).
//
// Parameters:
//   TICK_DIV   clocks between consecutive strobes (>= 1)
//   CNT_W      width of the step count / remaining-step counter
// Ports:
//   clk_out    in   block clock (shared with the shifter)
//   rst        in   asynchronous active-high reset
//   cmd_valid  in   command request
//   cmd_ready  out  high while idle; accept on cmd_valid & cmd_ready
//   cmd_mode   in   shifter mode code, passed through unmodified
//   cmd_count  in   number of steps (0 = no steps)
//   mode       out  registered mode to the shifter
//   en         out  registered one-cycle step strobe
//   busy       out  high while a command is running or completing
//   done       out  one-cycle completion pulse
//   step_left  out  remaining steps
//   abort      in   (SEQ_ABORT_EN only) end the running command early

module shift_seq_ctrl #(
   parameter int TICK_DIV = 4,
   parameter int CNT_W    = 4
) (
   input  logic             clk_out,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_mode,
   input  logic [CNT_W-1:0] cmd_count,
   output logic [2:0]       mode,
   output logic             en,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] step_left
`ifdef SEQ_ABORT_EN
   ,
   input  logic             abort
`endif
);

   // A prescaler of width 1 still works when TICK_DIV is 1 (reload value 0).
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_RELOAD = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state, state_n;
   logic [PW-1:0]    presc, presc_n;
   logic [CNT_W-1:0] step_n;
   logic [2:0]       mode_n;
   logic             en_n;
   logic             done_n;
   logic             abort_req;

`ifdef SEQ_ABORT_EN
   assign abort_req = abort;
`else
   assign abort_req = 1'b0;
`endif

   assign cmd_ready = (state == S_IDLE);
   assign busy      = (state != S_IDLE);

   always_ff @(posedge clk_out or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         presc     <= '0;
         step_left <= '0;
         mode      <= 3'b000;
         en        <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_n;
         presc     <= presc_n;
         step_left <= step_n;
         mode      <= mode_n;
         en        <= en_n;
         done      <= done_n;
      end
   end

   always_comb begin
      state_n = state;
      presc_n = presc;
      step_n  = step_left;
      mode_n  = mode;
      en_n    = 1'b0;
      done_n  = 1'b0;

      case (state)
         S_IDLE: begin
            if (cmd_valid) begin
               mode_n = cmd_mode;
               step_n = cmd_count;
               if (cmd_count == '0) begin
                  state_n = S_DONE;
               end else begin
                  presc_n = PRESC_RELOAD;
                  state_n = S_RUN;
               end
            end
         end

         S_RUN: begin
            if (abort_req) begin
               // step_left freezes; the strobe already on `en` was sampled.
               state_n = S_DONE;
            end else if (presc != '0) begin
               presc_n = presc - 1'b1;
            end else begin
               presc_n = PRESC_RELOAD;
               if (step_left != '0) begin
                  en_n   = 1'b1;
                  step_n = step_left - 1'b1;
               end
               if (step_left <= CNT_W'(1)) begin
                  state_n = S_DONE;
               end
            end
         end

         S_DONE: begin
            // First DONE cycle raises the pulse; the second returns to idle,
            // so busy covers the whole pulse and ready follows one cycle later.
            if (!done) begin
               done_n = 1'b1;
            end else begin
               state_n = S_IDLE;
            end
         end

         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb/tb_shift_seq_ctrl.sv - self-checking bench for shift_seq_ctrl
module tb_shift_seq_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       cv [2];
   logic [2:0] cm [2];
   logic [3:0] cc [2];
   logic       cr [2];
   logic       en [2];
   logic       bz [2];
   logic       dn [2];
   logic [2:0] md [2];
   logic [3:0] sl [2];
`ifdef SEQ_ABORT_EN
   logic       ab [2];
`endif

   int checks   = 0;
   int failures = 0;

   // Instance 0: TICK_DIV=4, instance 1: TICK_DIV=1.
   shift_seq_ctrl #(.TICK_DIV(4), .CNT_W(4)) u_div4 (
      .clk_out(clk), .rst(rst), .cmd_valid(cv[0]), .cmd_ready(cr[0]),
      .cmd_mode(cm[0]), .cmd_count(cc[0]), .mode(md[0]), .en(en[0]),
      .busy(bz[0]), .done(dn[0]), .step_left(sl[0])
`ifdef SEQ_ABORT_EN
      , .abort(ab[0])
`endif
   );

   shift_seq_ctrl #(.TICK_DIV(1), .CNT_W(4)) u_div1 (
      .clk_out(clk), .rst(rst), .cmd_valid(cv[1]), .cmd_ready(cr[1]),
      .cmd_mode(cm[1]), .cmd_count(cc[1]), .mode(md[1]), .en(en[1]),
      .busy(bz[1]), .done(dn[1]), .step_left(sl[1])
`ifdef SEQ_ABORT_EN
      , .abort(ab[1])
`endif
   );

   localparam logic [10:0] RESET_VEC = {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0};

   // Observed outputs packed as {cmd_ready, busy, en, done, step_left, mode}.
   function automatic logic [10:0] obs(input int d);
      return {cr[d], bz[d], en[d], dn[d], sl[d], md[d]};
   endfunction

   // Expected outputs k edges after the accept edge, from the timing rules:
   // strobes after E(i*t), i=1..n; done after E(n*t+1); ready after E(n*t+2).
   function automatic logic [10:0] model(input int k, input int n, input int t,
                                         input logic [2:0] m);
      logic       e_en, e_dn, e_bz;
      int         taken;
      logic [3:0] e_sl;
      e_en  = (k % t == 0) && (k / t >= 1) && (k / t <= n);
      taken = (k / t < n) ? k / t : n;
      e_sl  = 4'(n - taken);
      e_dn  = (k == n * t + 1);
      e_bz  = (k >= 1) && (k <= n * t + 1);
      return {~e_bz, e_bz, e_en, e_dn, e_sl, m};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Runs one command through instance d and checks every cycle until ready.
   task automatic run_cmd(input int d, input logic [2:0] m, input int n,
                          input bit intrude, output int strobes, output int done_k);
      int t;
      int waitc;
      t = (d == 0) ? 4 : 1;
      waitc = 0;
      while (!cr[d] && waitc < 100) begin
         @(posedge clk); #1;
         waitc++;
      end
      if (!cr[d]) chk("ready_timeout", 32'(cr[d]), 32'd1);
      cv[d] = 1'b1;
      cm[d] = m;
      cc[d] = 4'(n);
      @(posedge clk); #1;
      strobes = 0;
      done_k  = -1;
      cv[d] = intrude && (0 < n * t);
      cm[d] = ~m;
      cc[d] = 4'($urandom_range(0, 15));
      for (int k = 1; k <= n * t + 2; k++) begin
         @(posedge clk); #1;
         chk($sformatf("cycle d%0d n%0d k%0d", d, n, k), 32'(obs(d)), 32'(model(k, n, t, m)));
         if (en[d]) strobes++;
         if (dn[d]) done_k = k;
         cv[d] = intrude && (k < n * t);
      end
      cv[d] = 1'b0;
   endtask

   typedef struct {
      int         d;
      logic [2:0] m;
      int         n;
      bit         intrude;
      int         exp_strobes;
      int         exp_done_k;
   } vec_t;

   vec_t tbl [7];

   initial begin
      int s, dk, d, n;
      logic [2:0] m;
      logic [2:0] last_mode0;

      tbl[0] = '{0, 3'b001,  3, 1'b0,  3, 13};
      tbl[1] = '{0, 3'b101,  0, 1'b0,  0,  1};
      tbl[2] = '{0, 3'b010,  2, 1'b1,  2,  9};
      tbl[3] = '{1, 3'b011,  5, 1'b0,  5,  6};
      tbl[4] = '{1, 3'b110, 15, 1'b1, 15, 16};
      tbl[5] = '{0, 3'b111, 15, 1'b0, 15, 61};
      tbl[6] = '{1, 3'b100,  0, 1'b1,  0,  1};

      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         cv[i] = 1'b0; cm[i] = 3'd0; cc[i] = 4'd0;
`ifdef SEQ_ABORT_EN
         ab[i] = 1'b0;
`endif
      end
      repeat (3) @(posedge clk);
      #1;
      chk("reset_div4", 32'(obs(0)), 32'(RESET_VEC));
      chk("reset_div1", 32'(obs(1)), 32'(RESET_VEC));
      rst = 1'b0;
      @(posedge clk); #1;
      chk("post_reset_idle", 32'(obs(0)), 32'(RESET_VEC));

      last_mode0 = 3'd0;
      for (int i = 0; i < 7; i++) begin
         run_cmd(tbl[i].d, tbl[i].m, tbl[i].n, tbl[i].intrude, s, dk);
         chk($sformatf("tbl%0d strobes", i), 32'(s), 32'(tbl[i].exp_strobes));
         chk($sformatf("tbl%0d done_k", i), 32'(dk), 32'(tbl[i].exp_done_k));
         if (tbl[i].d == 0) last_mode0 = tbl[i].m;
      end

      // mode holds through idle until the next accept
      repeat (3) @(posedge clk);
      #1;
      chk("idle_mode_hold", 32'(md[0]), 32'(last_mode0));

      for (int i = 0; i < 24; i++) begin
         d = int'($urandom_range(0, 1));
         m = 3'($urandom_range(0, 7));
         n = int'($urandom_range(0, 15));
         run_cmd(d, m, n, 1'($urandom_range(0, 1)), s, dk);
         chk($sformatf("rnd%0d strobes", i), 32'(s), 32'(n));
         chk($sformatf("rnd%0d done_k", i), 32'(dk), 32'(n * ((d == 0) ? 4 : 1) + 1));
      end

      // Asynchronous reset mid-command: count=3, reset after E6.
      cv[0] = 1'b1; cm[0] = 3'b011; cc[0] = 4'd3;
      @(posedge clk); #1;
      cv[0] = 1'b0;
      repeat (6) @(posedge clk);
      #3 rst = 1'b1;
      #1 chk("async_reset", 32'(obs(0)), 32'(RESET_VEC));
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         chk($sformatf("post_rst k%0d", k), 32'(obs(0)), 32'(RESET_VEC));
      end

`ifdef SEQ_ABORT_EN
      // abort at E6 of count=3: no further strobes, step_left=2, done after E7.
      cv[0] = 1'b1; cm[0] = 3'b011; cc[0] = 4'd3;
      @(posedge clk); #1;
      cv[0] = 1'b0;
      repeat (5) @(posedge clk);
      #1 ab[0] = 1'b1;
      @(posedge clk); #1;
      ab[0] = 1'b0;
      chk("abort_e6", 32'(obs(0)), 32'({1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 3'b011}));
      @(posedge clk); #1;
      chk("abort_e7", 32'(obs(0)), 32'({1'b0, 1'b1, 1'b0, 1'b1, 4'd2, 3'b011}));
      @(posedge clk); #1;
      chk("abort_e8", 32'(obs(0)), 32'({1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 3'b011}));
      // abort while idle is ignored
      ab[0] = 1'b1;
      @(posedge clk); #1;
      ab[0] = 1'b0;
      chk("abort_idle", 32'(obs(0)), 32'({1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 3'b011}));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
